// File: rtl/apb_bus_arbiter_if.sv
// Bundle of requester-side and APB-side signals for apb_bus_arbiter.
// The master modport is the arbiter's view: it accepts requests, returns
// completions and drives the APB bus towards the slave.
interface apb_bus_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    // requester side
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;

    // APB side
    logic [AW-1:0]      paddr;
    logic               pwrite;
    logic [DW-1:0]      pwdata;
    logic               psel;
    logic               penable;
    logic [DW-1:0]      prdata;
    logic               pready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               paddr, pwrite, pwdata, psel, penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               paddr, pwrite, pwdata, psel, penable
    );
endinterface

// File: rtl/apb_bus_arbiter.sv
// Round-robin APB master shared by NREQ requesters. Each grant runs one
// SETUP/ACCESS transfer; ACCESS waits on pready and gives up after TIMEOUT
// cycles (TIMEOUT = 0 waits forever). Completion is a registered one-cycle
// pulse on rsp_valid for the owning requester.
module apb_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                prst,
    apb_bus_arbiter_if.master   bus
);
    localparam int PW = $clog2(NREQ);
    // The counter only needs to reach TIMEOUT-1: the last ACCESS cycle is
    // recognised while the counter still shows it.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_e;

    state_e          state_q,     state_d;
    logic [AW-1:0]   paddr_q,     paddr_d;
    logic            pwrite_q,    pwrite_d;
    logic [DW-1:0]   pwdata_q,    pwdata_d;
    logic            psel_q,      psel_d;
    logic            penable_q,   penable_d;
    logic [PW-1:0]   owner_q,     owner_d;
    logic [PW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [CW-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [NREQ-1:0] ready_vec;

    // Round-robin winner: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        // Scan from the far end so the closest candidate is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    // Accept strobe: one-hot to the winner, only while idle and out of reset.
    always_comb begin
        ready_vec = '0;
        if (!prst && state_q == S_IDLE && grant_found) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    // Next-state and registered-output logic of the transfer FSM.
    always_comb begin
        // NOTE: every target gets a default first, so no path can leave a
        // variable unassigned and infer a latch.
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    paddr_d   = bus.req_addr[grant_idx*AW +: AW];
                    pwrite_d  = bus.req_write[grant_idx];
                    pwdata_d  = bus.req_wdata[grant_idx*DW +: DW];
                    owner_d   = grant_idx;
                    rr_ptr_d  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.pready) begin
                    // pready wins even on the last allowed cycle.
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : bus.prdata;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    state_d              = S_IDLE;
                end else if (TIMEOUT != 0 && wait_cnt_q == LAST_WAIT) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    state_d              = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset drops any
    // transfer in flight without a completion pulse.
    always_ff @(posedge pclk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (prst) begin
            state_q     <= S_IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Testbench for apb_bus_arbiter: directed scenarios with literal expectations,
// then random traffic, all continuously compared against a transfer-level
// model of the arbiter kept in this file.
module tb_apb_bus_arbiter;
    localparam int NREQ    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic pclk = 1'b0;
    logic prst = 1'b1;

    always #5 pclk = ~pclk;

    apb_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    apb_bus_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transfer-level model: a transfer is "in flight" from its accept edge;
    // m_age counts cycles since accept (1 = select phase, >=2 = enable phase,
    // enable-phase cycle number = m_age-1).
    // ------------------------------------------------------------------
    bit              m_busy   = 0;
    int              m_age    = 0;
    int              m_owner  = 0;
    int              m_rr     = 0;
    logic [AW-1:0]   m_paddr  = '0;
    logic            m_pwrite = 1'b0;
    logic [DW-1:0]   m_pwdata = '0;
    logic [NREQ-1:0] m_rsp_valid = '0;
    logic [DW-1:0]   m_rsp_rdata = '0;
    logic            m_rsp_err   = 1'b0;
    logic [NREQ-1:0] m_acc       = '0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int w;
        if (prst || m_busy) return '0;
        w = rr_pick(bus.req_valid, m_rr);
        if (w < 0) return '0;
        return NREQ'(1) << w;
    endfunction

    task automatic model_edge();
        int w;
        m_acc       = '0;
        m_rsp_valid = '0;
        m_rsp_rdata = '0;
        m_rsp_err   = 1'b0;
        if (prst) begin
            m_busy = 0; m_age = 0; m_rr = 0;
            m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
        end else if (!m_busy) begin
            w = rr_pick(bus.req_valid, m_rr);
            if (w >= 0) begin
                m_busy   = 1;
                m_age    = 1;
                m_owner  = w;
                m_paddr  = bus.req_addr[w*AW +: AW];
                m_pwrite = bus.req_write[w];
                m_pwdata = bus.req_wdata[w*DW +: DW];
                m_rr     = (w + 1) % NREQ;
                m_acc[w] = 1'b1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            if (bus.pready) begin
                m_rsp_valid[m_owner] = 1'b1;
                m_rsp_rdata = m_pwrite ? '0 : bus.prdata;
                m_busy = 0;
            end else if (TIMEOUT != 0 && (m_age - 1) == TIMEOUT) begin
                m_rsp_valid[m_owner] = 1'b1;
                m_rsp_err = 1'b1;
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    // Compare process: registered outputs just after each edge, the
    // combinational accept strobe at the falling edge.
    initial begin
        forever begin
            @(posedge pclk);
            model_edge();
            #1;
            check("psel",      bus.psel,      m_busy);
            check("penable",   bus.penable,   m_busy && m_age >= 2);
            check("paddr",     bus.paddr,     m_paddr);
            check("pwrite",    bus.pwrite,    m_pwrite);
            check("pwdata",    bus.pwdata,    m_pwdata);
            check("rsp_valid", bus.rsp_valid, m_rsp_valid);
            if (m_rsp_valid != '0) begin
                check("rsp_rdata", bus.rsp_rdata, m_rsp_rdata);
                check("rsp_err",   bus.rsp_err,   m_rsp_err);
            end
            @(negedge pclk);
            check("req_ready", bus.req_ready, exp_ready());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #3;
    endtask

    task automatic new_req(input int i);
        bus.req_valid[i]           = 1'b1;
        bus.req_write[i]           = 1'($urandom_range(0, 1));
        bus.req_addr[i*AW +: AW]   = $urandom;
        bus.req_wdata[i*DW +: DW]  = $urandom;
    endtask

    // Stimulus with literal expectations for the directed scenarios.
    initial begin
        int stuck;
        logic [NREQ-1:0] exp_rdy;
        stuck = 0;
        bus.req_valid = 3'b001;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.pready    = 1'b1;
        bus.prdata    = '0;

        // Reset: pending request must not be accepted while prst is high.
        tick(); tick();
        #1 check("rst_ready", bus.req_ready, 3'b000);
        bus.req_valid = '0;
        prst = 1'b0;
        check("rst_psel",      bus.psel,      1'b0);
        check("rst_penable",   bus.penable,   1'b0);
        check("rst_paddr",     bus.paddr,     32'h0);
        check("rst_rsp_valid", bus.rsp_valid, 3'b000);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);

        // Zero-wait write from requester 0.
        bus.req_valid = 3'b001;
        bus.req_write = 3'b001;
        bus.req_addr[0 +: AW]  = 32'h10;
        bus.req_wdata[0 +: DW] = 32'hDEADBEEF;
        #1 check("t1_ready", bus.req_ready, 3'b001);
        tick(); bus.req_valid = '0;
        check("t1_setup_psel",    bus.psel,    1'b1);
        check("t1_setup_penable", bus.penable, 1'b0);
        check("t1_setup_paddr",   bus.paddr,   32'h10);
        check("t1_setup_pwrite",  bus.pwrite,  1'b1);
        tick();
        check("t1_access_penable", bus.penable,   1'b1);
        check("t1_access_no_rsp",  bus.rsp_valid, 3'b000);
        tick();
        check("t1_rsp_valid", bus.rsp_valid, 3'b001);
        check("t1_rsp_err",   bus.rsp_err,   1'b0);
        check("t1_psel_low",  bus.psel,      1'b0);

        // Zero-wait read from requester 1.
        bus.req_valid = 3'b010;
        bus.req_write = 3'b000;
        bus.req_addr[AW +: AW] = 32'h5;
        bus.prdata = 32'h5;
        #1 check("t2_ready", bus.req_ready, 3'b010);
        tick(); bus.req_valid = '0;
        check("t2_setup_pwrite", bus.pwrite, 1'b0);
        check("t2_setup_paddr",  bus.paddr,  32'h5);
        tick();
        check("t2_access_pwrite", bus.pwrite, 1'b0);
        tick();
        check("t2_rsp_valid", bus.rsp_valid, 3'b010);
        check("t2_rsp_rdata", bus.rsp_rdata, 32'h5);
        check("t2_rsp_err",   bus.rsp_err,   1'b0);

        // Two requesters out of reset: grants 0,1,0,1 spaced 3 cycles apart.
        prst = 1'b1;
        tick();
        prst = 1'b0;
        bus.req_valid = 3'b011;
        bus.req_addr[0 +: AW]  = 32'h100;
        bus.req_addr[AW +: AW] = 32'h104;
        for (int c = 0; c < 10; c++) begin
            if (c % 3 != 0)           exp_rdy = 3'b000;
            else if ((c / 3) % 2 == 0) exp_rdy = 3'b001;
            else                       exp_rdy = 3'b010;
            #1 check("t3_ready", bus.req_ready, exp_rdy);
            tick();
        end
        bus.req_valid = '0;
        tick(); tick();
        check("t3_last_rsp", bus.rsp_valid, 3'b010);

        // Three wait states, ready on the 4th (= last allowed) ACCESS cycle.
        bus.req_valid = 3'b001;
        bus.req_write = 3'b001;
        bus.req_addr[0 +: AW]  = 32'h20;
        bus.req_wdata[0 +: DW] = 32'h12345678;
        bus.pready = 1'b0;
        tick(); bus.req_valid = '0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("t4_penable", bus.penable,   1'b1);
            check("t4_paddr",   bus.paddr,     32'h20);
            check("t4_pwdata",  bus.pwdata,    32'h12345678);
            check("t4_no_rsp",  bus.rsp_valid, 3'b000);
            if (k == 4) bus.pready = 1'b1;
            tick();
        end
        check("t4_rsp_valid", bus.rsp_valid, 3'b001);
        check("t4_rsp_err",   bus.rsp_err,   1'b0);
        check("t4_psel_low",  bus.psel,      1'b0);

        // Timeout: pready stuck low; queued requester 2 granted afterwards.
        bus.req_valid = 3'b110;
        bus.req_write = 3'b100;
        bus.req_addr[AW +: AW]     = 32'h30;
        bus.req_addr[2*AW +: AW]   = 32'h40;
        bus.req_wdata[2*DW +: DW]  = 32'hCAFEF00D;
        bus.pready = 1'b0;
        bus.prdata = 32'hAAAA5555;
        #1 check("t5_ready", bus.req_ready, 3'b010);
        tick(); bus.req_valid = 3'b100;
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("t5_access_psel", bus.psel,    1'b1);
            check("t5_access_pen",  bus.penable, 1'b1);
            tick();
        end
        check("t5_psel_low",  bus.psel,      1'b0);
        check("t5_rsp_valid", bus.rsp_valid, 3'b010);
        check("t5_rsp_err",   bus.rsp_err,   1'b1);
        check("t5_rsp_rdata", bus.rsp_rdata, 32'h0);
        #1 check("t5_next_ready", bus.req_ready, 3'b100);
        bus.pready = 1'b1;
        tick(); bus.req_valid = '0;
        tick(); tick();
        check("t5_rsp2_valid", bus.rsp_valid, 3'b100);
        check("t5_rsp2_err",   bus.rsp_err,   1'b0);

        // Reset during ACCESS: no completion, pointer back to 0.
        bus.req_valid = 3'b001;
        bus.req_write = 3'b001;
        bus.req_addr[0 +: AW]  = 32'h50;
        bus.req_wdata[0 +: DW] = 32'h55;
        bus.pready = 1'b0;
        tick(); bus.req_valid = '0;
        tick();
        check("t6_in_access", bus.penable, 1'b1);
        prst = 1'b1;
        bus.req_valid = 3'b011;
        bus.req_write = 3'b000;
        bus.req_addr[AW +: AW] = 32'h60;
        #1 check("t6_ready_in_rst", bus.req_ready, 3'b000);
        tick();
        check("t6_psel",      bus.psel,      1'b0);
        check("t6_penable",   bus.penable,   1'b0);
        check("t6_paddr",     bus.paddr,     32'h0);
        check("t6_rsp_valid", bus.rsp_valid, 3'b000);
        prst = 1'b0;
        bus.pready = 1'b1;
        #1 check("t6_ready0", bus.req_ready, 3'b001);
        tick(); bus.req_valid = 3'b010;
        check("t6_no_rsp_a", bus.rsp_valid, 3'b000);
        tick();
        check("t6_no_rsp_b", bus.rsp_valid, 3'b000);
        tick();
        check("t6_rsp0", bus.rsp_valid, 3'b001);
        #1 check("t6_ready1", bus.req_ready, 3'b010);
        tick(); bus.req_valid = '0;
        tick(); tick();
        check("t6_rsp1", bus.rsp_valid, 3'b010);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc[i]) bus.req_valid[i] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) new_req(i);
            end
            if (stuck > 0) begin
                bus.pready = 1'b0;
                stuck--;
            end else if ($urandom_range(0, 19) == 0) begin
                bus.pready = 1'b0;
                stuck = $urandom_range(3, 8);
            end else begin
                bus.pready = ($urandom_range(0, 3) != 0);
            end
            bus.prdata = $urandom;
            prst = ($urandom_range(0, 299) == 0);
        end

        prst = 1'b0;
        bus.req_valid = '0;
        bus.pready = 1'b1;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
